range_image_reader: RTL
=======================

# range_image_reader

Reads a packed 16-bit range image back from EXT memory and streams it out pixel by pixel in raster order with (x, y) coordinates. It is the read-side counterpart of the range-image write-back path, which packs four range values per 64-bit EXT memory word. It sits between the EXT memory read channel and any downstream consumer of the range image, such as a filter, a compressor or a host readback path.

## Interface
- IMG_WIDTH, 2048: columns per row; must be a multiple of 4.
- IMG_HEIGHT, 64: rows per image.
- i_SYSTEM_clk  in  1  single clock; all logic rising-edge.
- i_SYSTEM_rst  in  1  asynchronous reset, active-low (reset asserted when 0).
- i_start  in  1  start pulse; sampled only in IDLE.
- i_baseAddress  in  32  image byte base address; latched on accepted i_start; bits [2:0] forced to 0.
- EXT_MEM_readAddress  out  32  byte address of the current 64-bit word.
- EXT_MEM_initReadTxn  out  1  one-cycle read request pulse.
- EXT_MEM_readPayload  in  64  read data; valid when EXT_MEM_readTxnDone=1.
- EXT_MEM_readTxnDone  in  1  read completion.
- EXT_MEM_error  in  1  memory error.
- o_valid  out  1  pixel valid.
- i_ready  in  1  consumer ready.
- o_range  out  16  range value.
- o_x  out  16  column, 0..IMG_WIDTH-1.
- o_y  out  8  row, 0..IMG_HEIGHT-1.
- o_last  out  1  high with the final pixel of the image.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the image is complete.
- o_error  out  1  sticky; cleared by the next accepted i_start.

## Operation
- **State machine:** IDLE, REQ, WAIT, DRAIN, DONE.
- **IDLE:** when i_start=1, latch the base address, clear the word index, x, y and o_error, then go to REQ. i_start is ignored in every other state.
- **REQ:**
  - Drive EXT_MEM_initReadTxn=1 for exactly one cycle, with EXT_MEM_readAddress = base + 8*word_index.
  - Then go to WAIT. The address is held stable until the next REQ.
- **WAIT:**
  - On EXT_MEM_readTxnDone=1, capture EXT_MEM_readPayload into the word buffer, clear the lane index and go to DRAIN.
  - On EXT_MEM_error=1 (this takes priority over a simultaneous readTxnDone), set o_error and go to IDLE without pulsing o_done.
- **DRAIN:**
  - Present lane k = payload[16k+15:16k], lane 0 first, on o_range.
  - A transfer occurs when o_valid=1 and i_ready=1. On each transfer, advance the lane index and x. When x reaches IMG_WIDTH-1 it wraps to 0 and y increments.
  - After lane 3 transfers: if word_index = IMG_WIDTH*IMG_HEIGHT/4 - 1, go to DONE; otherwise increment word_index and go to REQ.
- **o_last:** o_valid=1 with x=IMG_WIDTH-1 and y=IMG_HEIGHT-1.
- **DONE:** o_done=1 for one cycle, then go to IDLE.
- **Output stability:** o_range, o_x, o_y and o_last are held stable while o_valid=1 and i_ready=0.
- **Widths:** the word index is clog2(IMG_WIDTH*IMG_HEIGHT/4) bits. Address arithmetic is 32-bit, modulo 2^32 (wraps silently).
- **EXT_MEM_error outside WAIT** is ignored.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. Reset asserted mid-transfer aborts immediately. No outstanding transaction is tracked; after reset the block ignores EXT_MEM_readTxnDone until its next REQ.
- **Start latency:** i_start at cycle 0 → EXT_MEM_initReadTxn high in cycle 1.
- **Read-return latency:** EXT_MEM_readTxnDone at cycle t → o_valid=1 with lane 0 at cycle t+1.
- **Throughput:** with i_ready tied high, 4 pixels in 4 consecutive cycles, then REQ in the next cycle. The minimum period is 6 cycles per word plus memory latency. There is no prefetch.
- **o_valid** is 0 in IDLE, REQ, WAIT and DONE.
- **o_done** is asserted in the cycle after the final transfer.

## Configuration
- **RIR_ZERO_SKIP_EN defined:** lanes with range 0 are never presented.
  - Each such lane consumes one DRAIN cycle with o_valid=0 while x and y still advance.
  - If the final pixel is 0, o_last is never asserted; o_done still pulses.
- **RIR_ZERO_SKIP_EN undefined:** every pixel is presented, including zero-range pixels.

## Test plan
All scenarios use IMG_WIDTH=8 and IMG_HEIGHT=2 (4 words).
- **Full readback:** base 0x1000, memory words 0x0004_0003_0002_0001 and up, i_ready=1 → addresses 0x1000, 0x1008, 0x1010, 0x1018 in order; ranges 1..16; (x,y) runs (0,0)..(7,0),(0,1)..(7,1); o_last only on range 16; o_done exactly once.
- **Backpressure:** i_ready=0 for 5 cycles on lane 2 of word 1 → o_range, o_x and o_y held; no extra EXT_MEM_initReadTxn; data order unchanged.
- **Error:** EXT_MEM_error in WAIT for word 2 → o_error=1, o_busy=0, no o_done. A following i_start clears o_error and restarts at word 0.
- **Reset mid-DRAIN:** i_SYSTEM_rst=0 → all outputs 0 asynchronously; a new start reads from word 0.
- **Misaligned base and start-while-busy:** i_baseAddress=0x1005 → first address 0x1000; i_start pulsed in WAIT has no effect.
- **RIR_ZERO_SKIP_EN:** word 0 = 0x0000_0007_0000_0005 → only ranges 5 (x=0) and 7 (x=2) are presented.

Source files
------------

// File: rtl/range_image_reader.sv
// range_image_reader: streams a packed 16-bit range image (four pixels per 64-bit EXT word) in raster order.
// Build macro RIR_ZERO_SKIP_EN: zero-range pixels are not presented but still advance x/y.
module range_image_reader #(
    parameter int IMG_WIDTH  = 2048,
    parameter int IMG_HEIGHT = 64
) (
    input  logic        i_SYSTEM_clk,
    input  logic        i_SYSTEM_rst,
    input  logic        i_start,
    input  logic [31:0] i_baseAddress,
    output logic [31:0] EXT_MEM_readAddress,
    output logic        EXT_MEM_initReadTxn,
    input  logic [63:0] EXT_MEM_readPayload,
    input  logic        EXT_MEM_readTxnDone,
    input  logic        EXT_MEM_error,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_range,
    output logic [15:0] o_x,
    output logic [7:0]  o_y,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [2:0]  o_dbg_state
);
    localparam int NWORDS = IMG_WIDTH * IMG_HEIGHT / 4;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
    localparam logic [15:0] X_MAX = 16'(IMG_WIDTH - 1);
    localparam logic [7:0]  Y_MAX = 8'(IMG_HEIGHT - 1);
`ifdef RIR_ZERO_SKIP_EN
    localparam logic ZERO_SKIP = 1'b1;
`else
    localparam logic ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       addr_q, addr_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [WIDX_W-1:0] widx_inc;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        lane_nx;
    logic [15:0]       x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [63:0]       buf_q, buf_d;
    logic              txn_q, txn_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    function automatic logic lane_present(input logic [15:0] r);
        return !ZERO_SKIP || (r != 16'd0);
    endfunction

    assign widx_inc = widx_q + 1'b1;
    assign lane_nx  = lane_q + 2'd1;

    // Handshake: a pixel moves on a rising edge with o_valid=1 and i_ready=1; while o_valid=1
    // and i_ready=0 the pixel fields hold. A skipped (invalid) lane advances unconditionally.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        widx_d  = widx_q;
        lane_d  = lane_q;
        x_d     = x_q;
        y_d     = y_q;
        buf_d   = buf_q;
        txn_d   = 1'b0;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d  = i_baseAddress & ~32'h7;
                    addr_d  = i_baseAddress & ~32'h7;
                    widx_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    err_d   = 1'b0;
                    txn_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (EXT_MEM_error) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (EXT_MEM_readTxnDone) begin
                    buf_d   = EXT_MEM_readPayload;
                    lane_d  = 2'd0;
                    valid_d = lane_present(EXT_MEM_readPayload[15:0]);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!valid_q || i_ready) begin
                    if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = (y_q == Y_MAX) ? 8'd0 : y_q + 8'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    lane_d = lane_nx;
                    if (lane_q == 2'd3) begin
                        valid_d = 1'b0;
                        if (widx_q == LAST_WORD) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            widx_d  = widx_inc;
                            addr_d  = base_q + (32'(widx_inc) << 3);
                            txn_d   = 1'b1;
                            state_d = S_REQ;
                        end
                    end else begin
                        valid_d = lane_present(buf_q[{lane_nx, 4'b0000} +: 16]);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            buf_q   <= '0;
            txn_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            widx_q  <= widx_d;
            lane_q  <= lane_d;
            x_q     <= x_d;
            y_q     <= y_d;
            buf_q   <= buf_d;
            txn_q   <= txn_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign EXT_MEM_readAddress = addr_q;
    assign EXT_MEM_initReadTxn = txn_q;
    assign o_valid     = valid_q;
    assign o_range     = buf_q[{lane_q, 4'b0000} +: 16];
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_last      = valid_q && (x_q == X_MAX) && (y_q == Y_MAX);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_error     = err_q;
    assign o_dbg_state = state_q;

endmodule
